// File: rtl/stdp_train_ctrl_if.sv
// rtl/stdp_train_ctrl_if.sv - host and neuron signal bundle for the STDP training controller
interface stdp_train_ctrl_if #(
   parameter int STEP_W = 8
);
   logic              start;
   logic              abort;
   logic [7:0]        pattern;
   logic [STEP_W-1:0] steps;
   logic              learn_en;
   logic              spike_in;
   logic [7:0]        neuron_inputs;
   logic              learn;
   logic              busy;
   logic              done;
   logic [7:0]        spike_count;

   // Host/neuron side: drives requests and the neuron spike, observes the controller.
   modport master (
      output start, abort, pattern, steps, learn_en, spike_in,
      input  neuron_inputs, learn, busy, done, spike_count
   );

   // Controller side.
   modport slave (
      input  start, abort, pattern, steps, learn_en, spike_in,
      output neuron_inputs, learn, busy, done, spike_count
   );
endinterface

// File: rtl/stdp_train_ctrl.sv
// rtl/stdp_train_ctrl.sv - presents a latched spike pattern to one STDP neuron with refractory gating
module stdp_train_ctrl #(
   parameter int REFRACT = 3,
   parameter int STEP_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   stdp_train_ctrl_if.slave bus
);
   localparam int REF_W = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      REFR = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
   logic [7:0]        pattern_q, pattern_d;
   logic              learn_en_q, learn_en_d;
   logic [7:0]        count_q, count_d;

   logic [STEP_W-1:0] step_nxt;
   logic              last_step;
   logic [7:0]        count_inc;

   assign step_nxt  = step_cnt_q + 1'b1;
   assign last_step = (step_nxt == steps_q);
   assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         step_cnt_q <= '0;
         steps_q    <= '0;
         ref_cnt_q  <= '0;
         pattern_q  <= '0;
         learn_en_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         step_cnt_q <= step_cnt_d;
         steps_q    <= steps_d;
         ref_cnt_q  <= ref_cnt_d;
         pattern_q  <= pattern_d;
         learn_en_q <= learn_en_d;
         count_q    <= count_d;
      end
   end

   // Priority inside a presentation: abort, then completion, then spike handling.
   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      steps_d    = steps_q;
      ref_cnt_d  = ref_cnt_q;
      pattern_d  = pattern_q;
      learn_en_d = learn_en_q;
      count_d    = count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               pattern_d  = bus.pattern;
               steps_d    = bus.steps;
               learn_en_d = bus.learn_en;
               count_d    = '0;
               step_cnt_d = '0;
               ref_cnt_d  = '0;
               state_d    = (bus.steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               step_cnt_d = step_nxt;
               if (bus.spike_in) begin
                  count_d = count_inc;
               end
               if (last_step) begin
                  state_d = DONE;
               end else if (bus.spike_in && (REFRACT > 0)) begin
                  state_d   = REFR;
                  ref_cnt_d = REF_W'(REFRACT);
               end
            end
         end
         REFR: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               step_cnt_d = step_nxt;
               ref_cnt_d  = ref_cnt_q - 1'b1;
               if (last_step) begin
                  state_d = DONE;
               end else if (ref_cnt_q <= REF_W'(1)) begin
                  state_d = RUN;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.neuron_inputs = (state_q == RUN) ? pattern_q : 8'h00;
   assign bus.learn         = (state_q == RUN) ? learn_en_q : 1'b0;
   assign bus.busy          = (state_q == RUN) || (state_q == REFR);
   assign bus.done          = (state_q == DONE);
   assign bus.spike_count   = count_q;
endmodule

// File: tb/tb_stdp_train_ctrl.sv
// tb/tb_stdp_train_ctrl.sv - directed self-checking bench for stdp_train_ctrl
module tb_stdp_train_ctrl;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   stdp_train_ctrl_if #(.STEP_W(8)) ifa ();
   stdp_train_ctrl_if #(.STEP_W(8)) ifb ();
   stdp_train_ctrl_if #(.STEP_W(9)) ifc ();

   stdp_train_ctrl #(.REFRACT(3), .STEP_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
   stdp_train_ctrl #(.REFRACT(0), .STEP_W(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
   stdp_train_ctrl #(.REFRACT(0), .STEP_W(9)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      ifa.start = 0; ifa.abort = 0; ifa.pattern = 0; ifa.steps = 0; ifa.learn_en = 0; ifa.spike_in = 0;
      ifb.start = 0; ifb.abort = 0; ifb.pattern = 0; ifb.steps = 0; ifb.learn_en = 0; ifb.spike_in = 0;
      ifc.start = 0; ifc.abort = 0; ifc.pattern = 0; ifc.steps = 0; ifc.learn_en = 0; ifc.spike_in = 0;
      #12;
      chk("rst_inputs", ifa.neuron_inputs, 8'h00);
      chk("rst_learn", ifa.learn, 0);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_done", ifa.done, 0);
      chk("rst_count", ifa.spike_count, 0);
      reset = 1'b0;
      tick;

      // Plain presentation, 4 steps, no spikes.
      ifa.pattern = 8'hA5; ifa.steps = 8'd4; ifa.learn_en = 1'b1; ifa.start = 1'b1;
      tick;
      ifa.start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("t1_inputs_c%0d", c), ifa.neuron_inputs, 8'hA5);
         chk($sformatf("t1_learn_c%0d", c), ifa.learn, 1);
         chk($sformatf("t1_busy_c%0d", c), ifa.busy, 1);
         chk($sformatf("t1_done_c%0d", c), ifa.done, 0);
         tick;
      end
      chk("t1_done", ifa.done, 1);
      chk("t1_busy_end", ifa.busy, 0);
      chk("t1_inputs_end", ifa.neuron_inputs, 8'h00);
      chk("t1_count", ifa.spike_count, 0);
      tick;
      chk("t1_done_drop", ifa.done, 0);

      // One spike on RUN cycle 2, refractory 3, 10 steps.
      ifa.steps = 8'd10; ifa.start = 1'b1;
      tick;
      ifa.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         ifa.spike_in = (c == 2);
         chk($sformatf("t2_inputs_c%0d", c), ifa.neuron_inputs, (c >= 3 && c <= 5) ? 8'h00 : 8'hA5);
         chk($sformatf("t2_learn_c%0d", c), ifa.learn, (c >= 3 && c <= 5) ? 0 : 1);
         chk($sformatf("t2_busy_c%0d", c), ifa.busy, 1);
         chk($sformatf("t2_count_c%0d", c), ifa.spike_count, (c >= 3) ? 1 : 0);
         tick;
      end
      ifa.spike_in = 1'b0;
      chk("t2_done", ifa.done, 1);
      chk("t2_count", ifa.spike_count, 1);
      tick;

      // Spike held high: only RUN timesteps 1, 5, 9 count.
      ifa.steps = 8'd12; ifa.spike_in = 1'b1; ifa.start = 1'b1;
      tick;
      ifa.start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         chk($sformatf("t3_inputs_c%0d", c), ifa.neuron_inputs,
             (c == 1 || c == 5 || c == 9) ? 8'hA5 : 8'h00);
         chk($sformatf("t3_count_c%0d", c), ifa.spike_count,
             (c >= 10) ? 3 : (c >= 6) ? 2 : (c >= 2) ? 1 : 0);
         tick;
      end
      ifa.spike_in = 1'b0;
      chk("t3_done", ifa.done, 1);
      chk("t3_count", ifa.spike_count, 3);
      tick;

      // Zero steps, then start during DONE is ignored.
      ifa.steps = 8'd0; ifa.start = 1'b1;
      tick;
      ifa.steps = 8'd4;
      chk("t4_done", ifa.done, 1);
      chk("t4_busy", ifa.busy, 0);
      chk("t4_count", ifa.spike_count, 0);
      tick;
      ifa.start = 1'b0;
      chk("t4_ignored_busy", ifa.busy, 0);
      chk("t4_ignored_done", ifa.done, 0);
      tick;
      chk("t4_still_idle", ifa.busy, 0);

      // Abort on RUN cycle 3 with one spike counted, no refractory.
      ifb.pattern = 8'h3C; ifb.steps = 8'd10; ifb.learn_en = 1'b0; ifb.start = 1'b1;
      tick;
      ifb.start = 1'b0;
      ifb.spike_in = 1'b1;
      chk("t5_inputs_c1", ifb.neuron_inputs, 8'h3C);
      chk("t5_learn_c1", ifb.learn, 0);
      tick;
      ifb.spike_in = 1'b0;
      chk("t5_inputs_c2", ifb.neuron_inputs, 8'h3C);
      chk("t5_count_c2", ifb.spike_count, 1);
      tick;
      ifb.abort = 1'b1;
      chk("t5_busy_c3", ifb.busy, 1);
      tick;
      ifb.abort = 1'b0;
      chk("t5_busy_after", ifb.busy, 0);
      chk("t5_done_after", ifb.done, 0);
      chk("t5_count_after", ifb.spike_count, 1);
      chk("t5_inputs_after", ifb.neuron_inputs, 8'h00);
      tick;
      chk("t5_no_done", ifb.done, 0);

      // 255 steps with a spike every timestep.
      ifb.steps = 8'hFF; ifb.spike_in = 1'b1; ifb.start = 1'b1;
      tick;
      ifb.start = 1'b0;
      repeat (254) tick;
      chk("t6_busy_c255", ifb.busy, 1);
      chk("t6_count_c255", ifb.spike_count, 254);
      tick;
      ifb.spike_in = 1'b0;
      chk("t6_done", ifb.done, 1);
      chk("t6_count", ifb.spike_count, 255);
      tick;

      // 300 steps on a wider counter: count saturates, then async reset mid-run.
      ifc.pattern = 8'h81; ifc.steps = 9'd300; ifc.learn_en = 1'b1; ifc.spike_in = 1'b1; ifc.start = 1'b1;
      tick;
      ifc.start = 1'b0;
      repeat (259) tick;
      chk("t7_busy_c260", ifc.busy, 1);
      chk("t7_count_c260", ifc.spike_count, 255);
      repeat (10) tick;
      chk("t7_count_sat", ifc.spike_count, 255);
      chk("t7_inputs_run", ifc.neuron_inputs, 8'h81);
      #2;
      reset = 1'b1;
      #1;
      chk("t7_rst_inputs", ifc.neuron_inputs, 8'h00);
      chk("t7_rst_learn", ifc.learn, 0);
      chk("t7_rst_busy", ifc.busy, 0);
      chk("t7_rst_done", ifc.done, 0);
      chk("t7_rst_count", ifc.spike_count, 0);
      #2;
      reset = 1'b0;
      ifc.spike_in = 1'b0;
      tick;
      chk("t7_idle_busy", ifc.busy, 0);
      tick;
      chk("t7_idle_inputs", ifc.neuron_inputs, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
